// File: rtl/uart_fifo_bridge.sv
// Memory-mapped front end for the duplex UART: TX/RX FIFOs, sticky overrun flags,
// flush controls and a registered level interrupt, replacing the raw send/flag handshake.
module uart_fifo_bridge #(
    parameter int DATA_WIDTH    = 8,
    parameter int TX_DEPTH      = 16,
    parameter int RX_DEPTH      = 16,
    parameter int START_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_sel,
    input  logic [1:0]            bus_addr,
    input  logic                  bus_wren,
    input  logic                  bus_rden,
    input  logic [31:0]           bus_wrdata,
    output logic [31:0]           bus_rddata,
    output logic                  irq,
    output logic [DATA_WIDTH-1:0] uart_tx_data,
    output logic                  uart_tx_send,
    input  logic                  uart_busy,
    input  logic [DATA_WIDTH-1:0] uart_rx_data,
    input  logic                  uart_rx_flag,
    output logic                  uart_rx_clear
);

    localparam int TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int TO_W  = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

    localparam logic [TX_AW:0]   TX_LIMIT = TX_DEPTH[TX_AW:0];
    localparam logic [RX_AW:0]   RX_LIMIT = RX_DEPTH[RX_AW:0];
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(START_TIMEOUT - 1);
    localparam logic [TX_AW-1:0] TX_PTR_ONE = TX_AW'(1);
    localparam logic [RX_AW-1:0] RX_PTR_ONE = RX_AW'(1);
    localparam logic [TX_AW:0]   TX_CNT_ONE = (TX_AW + 1)'(1);
    localparam logic [RX_AW:0]   RX_CNT_ONE = (RX_AW + 1)'(1);
    localparam logic [TO_W-1:0]  TO_ONE     = TO_W'(1);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_LEVEL  = 2'd3;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_START = 2'd1;
    localparam logic [1:0] ST_WAIT_END   = 2'd2;

    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [TX_AW-1:0]      tx_wr_ptr, tx_rd_ptr;
    logic [RX_AW-1:0]      rx_wr_ptr, rx_rd_ptr;
    logic [TX_AW:0]        tx_count;
    logic [RX_AW:0]        rx_count;

    logic       rx_holdoff, rx_overrun, tx_overrun;
    logic       tx_enable, rx_ie, tx_ie;
    logic [1:0] tx_state;
    logic [TO_W-1:0] tx_timer;

    logic tx_empty, tx_full, rx_empty, rx_full, tx_active;
    logic wr_data, wr_status, wr_ctrl, rx_flush, tx_flush;
    logic rx_pop, rx_capture, rx_push, rx_drop;
    logic tx_launch, tx_push, tx_drop;
    logic unused_wrdata;

    assign tx_empty  = (tx_count == '0);
    assign tx_full   = (tx_count == TX_LIMIT);
    assign rx_empty  = (rx_count == '0);
    assign rx_full   = (rx_count == RX_LIMIT);
    assign tx_active = (tx_state != ST_IDLE);

    assign wr_data   = bus_sel & bus_wren & (bus_addr == ADDR_DATA);
    assign wr_status = bus_sel & bus_wren & (bus_addr == ADDR_STATUS);
    assign wr_ctrl   = bus_sel & bus_wren & (bus_addr == ADDR_CTRL);
    assign rx_flush  = wr_ctrl & bus_wrdata[0];
    assign tx_flush  = wr_ctrl & bus_wrdata[1];

    // The flag is a level held until our clear lands, so one sample per byte via holdoff.
    assign rx_pop     = bus_sel & bus_rden & (bus_addr == ADDR_DATA) & ~rx_empty;
    assign rx_capture = uart_rx_flag & ~rx_holdoff;
    assign rx_push    = rx_capture & (~rx_full | rx_pop);
    assign rx_drop    = rx_capture & rx_full & ~rx_pop;

    assign tx_launch = (tx_state == ST_IDLE) & ~tx_empty & tx_enable & ~uart_busy;
    assign tx_push   = wr_data & (~tx_full | tx_launch);
    assign tx_drop   = wr_data & tx_full & ~tx_launch;

    assign unused_wrdata = ^bus_wrdata[31:DATA_WIDTH];

    // NOTE: storage arrays carry no reset; pointers and counts define what is valid,
    // so clearing the data itself would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus_wrdata[DATA_WIDTH-1:0];
        if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || tx_flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push)   tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
            if (tx_launch) tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
            if (tx_push && !tx_launch)      tx_count <= tx_count + TX_CNT_ONE;
            else if (!tx_push && tx_launch) tx_count <= tx_count - TX_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
            if (rx_push && !rx_pop)      rx_count <= rx_count + RX_CNT_ONE;
            else if (!rx_push && rx_pop) rx_count <= rx_count - RX_CNT_ONE;
        end
    end

    // A flush never touches the FSM: a byte already loaded still goes out.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state     <= ST_IDLE;
            tx_timer     <= '0;
            uart_tx_data <= '0;
            uart_tx_send <= 1'b0;
        end else begin
            uart_tx_send <= 1'b0;
            case (tx_state)
                ST_IDLE: begin
                    if (tx_launch) begin
                        uart_tx_data <= tx_mem[tx_rd_ptr];
                        uart_tx_send <= 1'b1;
                        tx_timer     <= '0;
                        tx_state     <= ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (uart_busy)                tx_state <= ST_WAIT_END;
                    else if (tx_timer == TO_LIMIT) tx_state <= ST_IDLE;
                    else                          tx_timer <= tx_timer + TO_ONE;
                end
                ST_WAIT_END: begin
                    if (!uart_busy) tx_state <= ST_IDLE;
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_holdoff    <= 1'b0;
            uart_rx_clear <= 1'b0;
            rx_overrun    <= 1'b0;
            tx_overrun    <= 1'b0;
            tx_enable     <= 1'b1;
            rx_ie         <= 1'b0;
            tx_ie         <= 1'b0;
            irq           <= 1'b0;
        end else begin
            rx_holdoff    <= rx_capture;
            uart_rx_clear <= rx_capture;
            if (rx_drop && !rx_flush)             rx_overrun <= 1'b1;
            else if (wr_status && bus_wrdata[4])  rx_overrun <= 1'b0;
            if (tx_drop)                          tx_overrun <= 1'b1;
            else if (wr_status && bus_wrdata[5])  tx_overrun <= 1'b0;
            if (wr_ctrl) begin
                tx_enable <= bus_wrdata[2];
                rx_ie     <= bus_wrdata[3];
                tx_ie     <= bus_wrdata[4];
            end
            irq <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty);
        end
    end

    // NOTE: combinational outputs take a default first so no path can infer a latch.
    always_comb begin
        bus_rddata = '0;
        if (bus_sel) begin
            case (bus_addr)
                ADDR_DATA:   bus_rddata = rx_empty ? '0 : 32'(rx_mem[rx_rd_ptr]);
                ADDR_STATUS: bus_rddata = 32'({tx_active, tx_overrun, rx_overrun,
                                               tx_full, tx_empty, rx_full, rx_empty});
                ADDR_CTRL:   bus_rddata = 32'({tx_ie, rx_ie, tx_enable, 2'b00});
                default:     bus_rddata = {16'(tx_count), 16'(rx_count)};
            endcase
        end
    end

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Parametrised memory-mapped front end for the duplex UART. Replaces the direct tx_send / rx_flag handshake with TX and RX FIFOs, sticky overrun flags, flush controls and an interrupt line.
- Sits between the memory controller's peripheral decode and the UART_duplex instance.
- Lets the single-cycle core push or pop one byte per access without polling uart_busy per byte.

Parameters:
- DATA_WIDTH, 8, UART character width.
- TX_DEPTH, 16, TX FIFO entries; power of two, minimum 2.
- RX_DEPTH, 16, RX FIFO entries; power of two, minimum 2.
- START_TIMEOUT, 16, cycles to wait for uart_busy to rise after tx_send before abandoning the wait.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- bus_sel  in  1  peripheral selected this cycle.
- bus_addr  in  2  word offset: 0 DATA, 1 STATUS, 2 CTRL, 3 LEVEL.
- bus_wren  in  1  write strobe.
- bus_rden  in  1  read strobe; a DATA read with this strobe pops RX.
- bus_wrdata  in  32  write data.
- bus_rddata  out  32  combinational read data.
- irq  out  1  level interrupt.
- uart_tx_data  out  DATA_WIDTH  registered byte presented to the UART.
- uart_tx_send  out  1  one-cycle send pulse.
- uart_busy  in  1  UART transmitter busy.
- uart_rx_data  in  DATA_WIDTH  received byte.
- uart_rx_flag  in  1  received-byte-valid level.
- uart_rx_clear  out  1  one-cycle flag-clear pulse.

Behaviour:
- Reset: all registered outputs are 0; both FIFOs empty; overrun flags 0; tx_enable=1; rx_ie=0; tx_ie=0; TX FSM in IDLE; timeout counter 0.
- Read map (combinational, only when bus_sel is high; otherwise 0):
  - DATA: zero-extended RX head, or 0 if RX is empty.
  - STATUS: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_overrun, [5] tx_overrun, [6] tx_active (FSM not IDLE).
  - CTRL: [2] tx_enable, [3] rx_ie, [4] tx_ie; bits 0 and 1 read 0.
  - LEVEL: [15:0] rx count, [31:16] tx count. Counts span 0..DEPTH inclusive.
- Writes (on the clock edge with bus_sel & bus_wren):
  - DATA: push bus_wrdata[DATA_WIDTH-1:0] into TX. If TX is full and no same-cycle FSM pop occurs, drop the byte and set tx_overrun.
  - STATUS: write-1-to-clear bits 4 and 5.
  - CTRL: bit0=1 flushes RX; bit1=1 flushes TX; bits 2..4 are stored.
- RX pop: on the clock edge with bus_sel & bus_rden & addr==DATA & !rx_empty. A pop while empty has no effect.
- RX capture path:
  - Cycle N: uart_rx_flag is high and the holdoff bit is clear. Push uart_rx_data, pulse uart_rx_clear on cycle N+1, and set holdoff.
  - Cycle N+1: holdoff blocks re-sampling of the still-high flag. Holdoff clears at the end of N+1.
  - If RX is full with no same-cycle pop: drop the byte, set rx_overrun, still pulse uart_rx_clear.
  - Push and pop in the same cycle: both take effect, count unchanged, including when full.
- TX FSM:
  - IDLE: if !tx_empty & tx_enable & !uart_busy, load uart_tx_data from the head, pop, pulse uart_tx_send on the next cycle, go to WAIT_START, clear the counter.
  - WAIT_START: uart_busy=1 goes to WAIT_END. Otherwise increment the counter; reaching START_TIMEOUT-1 returns to IDLE (byte is considered sent).
  - WAIT_END: uart_busy=0 goes to IDLE.
  - Minimum spacing between consecutive send pulses is 3 cycles.
  - uart_tx_data holds stable from load until the next load.
  - Clearing tx_enable stops only new launches; an in-flight byte completes.
- Flush: a flush write empties the targeted FIFO at the edge and overrides any same-cycle push or pop on that FIFO. The TX flush does not abort an in-flight FSM byte.
- irq = (rx_ie & !rx_empty) | (tx_ie & tx_empty), registered, 1-cycle latency.
- Pointers wrap modulo DEPTH. Counts never exceed DEPTH and never underflow.
- rst asserted mid-transfer: immediate return to reset state; uart_tx_send and uart_rx_clear are low in the cycle following reset.

Test Plan:
- Write DATA 0x41, 0x42, 0x43 back-to-back with uart_busy modelled at 10 cycles per byte -> three uart_tx_send pulses carrying 0x41, 0x42, 0x43 in order; LEVEL[31:16] goes 3→0; tx_empty=1 at the end.
- Hold uart_busy=1 and write 17 bytes with TX_DEPTH=16 -> tx_full=1, tx_overrun=1, LEVEL[31:16]=16. Write STATUS 0x20 -> tx_overrun=0.
- Raise uart_rx_flag with 0x5A and hold it until uart_rx_clear -> exactly one uart_rx_clear pulse; LEVEL[15:0]=1; DATA read returns 0x5A, then reads return 0 with rx_empty=1.
- Fill RX to 16, then in one cycle present rx_flag 0x77 and pop via DATA -> pop returns the oldest byte, count stays 16, rx_overrun=0. A 17th byte with no pop -> rx_overrun=1, byte dropped.
- uart_busy never rises after a send, START_TIMEOUT=16 -> FSM back in IDLE 16 cycles after the pulse; the next byte launches.
- Set rx_ie=1 via CTRL 0x0C, receive one byte -> irq=1 one cycle after the push. Write CTRL 0x0D (flush RX) -> rx count 0, irq=0 the following cycle; rst mid-TX clears all outputs to 0.
